nasti_lite_byte_master: RTL

NASTI_LITE_BYTE_MASTER -- requirements
Module: nasti_lite_byte_master

---
 rtl/nasti_lite_byte_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nasti_lite_byte_master.sv
// nasti_lite_byte_master: turns UART command bytes into single-beat NASTI-lite writes/reads and replies with data/status bytes
module nasti_lite_byte_master #(
  parameter int NASTI_ID_WIDTH = 1,
  parameter int MASTER_ID = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      aw_valid,
  input  logic                      aw_ready,
  output logic [NASTI_ID_WIDTH-1:0] aw_id,
  output logic [7:0]                aw_addr,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic [7:0]                w_data,
  output logic                      w_strb,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [NASTI_ID_WIDTH-1:0] b_id,
  input  logic [1:0]                b_resp,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  output logic [NASTI_ID_WIDTH-1:0] ar_id,
  output logic [7:0]                ar_addr,
  input  logic                      r_valid,
  output logic                      r_ready,
  input  logic [NASTI_ID_WIDTH-1:0] r_id,
  input  logic [7:0]                r_data,
  input  logic [1:0]                r_resp,
  input  logic                      r_last
);
  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] GET_ADDR    = 4'd1;
  localparam logic [3:0] GET_DATA    = 4'd2;
  localparam logic [3:0] WR_REQ      = 4'd3;
  localparam logic [3:0] WR_RESP     = 4'd4;
  localparam logic [3:0] RD_REQ      = 4'd5;
  localparam logic [3:0] RD_RESP     = 4'd6;
  localparam logic [3:0] SEND_DATA   = 4'd7;
  localparam logic [3:0] SEND_STATUS = 4'd8;
  localparam logic [NASTI_ID_WIDTH-1:0] MID = NASTI_ID_WIDTH'(MASTER_ID);
  logic [3:0] state_q, state_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, status_q, status_d, tx_data_q, tx_data_d;
  logic       aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, ar_valid_q, ar_valid_d;
  logic       b_ready_q, b_ready_d, r_ready_q, r_ready_d, tx_valid_q, tx_valid_d, rx_ready_q, rx_ready_d;
  logic       rx_hs, tx_hs;
  logic       unused_r_last;
  assign unused_r_last = r_last;
  assign rx_hs = rx_valid && rx_ready_q;
  assign tx_hs = tx_valid_q && tx_ready;
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    case (state_q)
      IDLE: if (rx_hs) begin
        if (rx_data == 8'h01 || rx_data == 8'h02) begin
          wr_d    = rx_data == 8'h01;
          state_d = GET_ADDR;
        end else begin
          status_d = 8'hFF;
          state_d  = SEND_STATUS;
        end
      end
      GET_ADDR: if (rx_hs) begin
        addr_d     = rx_data;
        ar_valid_d = !wr_q;
        state_d    = wr_q ? GET_DATA : RD_REQ;
      end
      GET_DATA: if (rx_hs) begin
        wdata_d    = rx_data;
        aw_valid_d = 1'b1;
        w_valid_d  = 1'b1;
        state_d    = WR_REQ;
      end
      // each valid retires on its own handshake; leave once both have
      WR_REQ: begin
        aw_valid_d = aw_valid_q && !aw_ready;
        w_valid_d  = w_valid_q && !w_ready;
        state_d    = (!aw_valid_d && !w_valid_d) ? WR_RESP : WR_REQ;
      end
      WR_RESP: if (b_valid && b_ready_q) begin
        status_d = {5'b0, b_id != MID, b_resp};
        state_d  = SEND_STATUS;
      end
      RD_REQ: begin
        ar_valid_d = ar_valid_q && !ar_ready;
        state_d    = ar_valid_d ? RD_REQ : RD_RESP;
      end
      RD_RESP: if (r_valid && r_ready_q) begin
        rdata_d  = r_data;
        status_d = {5'b0, r_id != MID, r_resp};
        state_d  = SEND_DATA;
      end
      SEND_DATA:   state_d = tx_hs ? SEND_STATUS : SEND_DATA;
      SEND_STATUS: state_d = tx_hs ? IDLE : SEND_STATUS;
      default:     state_d = IDLE;
    endcase
    // handshake outputs are registered from the next state
    rx_ready_d = state_d == IDLE || state_d == GET_ADDR || state_d == GET_DATA;
    b_ready_d  = state_d == WR_RESP;
    r_ready_d  = state_d == RD_RESP;
    tx_valid_d = state_d == SEND_DATA || state_d == SEND_STATUS;
    tx_data_d  = state_d == SEND_DATA ? rdata_d : state_d == SEND_STATUS ? status_d : tx_data_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
      tx_data_q  <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      tx_data_q  <= tx_data_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
    end
  end
  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign aw_valid = aw_valid_q;
  assign aw_id    = MID;
  assign aw_addr  = addr_q;
  assign w_valid  = w_valid_q;
  assign w_data   = wdata_q;
  assign w_strb   = 1'b1;
  assign b_ready  = b_ready_q;
  assign ar_valid = ar_valid_q;
  assign ar_id    = MID;
  assign ar_addr  = addr_q;
  assign r_ready  = r_ready_q;
endmodule
